// File: rtl/bcd_2_bin_if.sv
// Request/result bundle for the sequential BCD-to-binary converter.
interface bcd_2_bin_if #(
    parameter int unsigned BCD_WIDTH = 3,
    parameter int unsigned BIN_WIDTH = 10
);
    logic                   start_i;
    logic [BCD_WIDTH*4-1:0] bcd_i;
    logic                   ready_o;
    logic                   valid_o;
    logic [BIN_WIDTH-1:0]   bin_o;
    logic                   ovf_o;
    logic                   err_o;

    modport master (
        output start_i, bcd_i,
        input  ready_o, valid_o, bin_o, ovf_o, err_o
    );

    modport slave (
        input  start_i, bcd_i,
        output ready_o, valid_o, bin_o, ovf_o, err_o
    );
endinterface

// File: rtl/bcd_2_bin.sv
// Sequential BCD-to-binary converter: one reverse double-dabble step per cycle.
// Optional invalid-digit flag on err_o when BCD_2_BIN_CHECK_EN is defined.
module bcd_2_bin #(
    parameter int unsigned BCD_WIDTH = 3,
    parameter int unsigned BIN_WIDTH = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    bcd_2_bin_if.slave   bus
);
    localparam int unsigned DIG_W = BCD_WIDTH * 4;
    localparam int unsigned CAT_W = DIG_W + BIN_WIDTH;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t               state;
    logic [DIG_W-1:0]     dig;
    logic [DIG_W-1:0]     dig_nxt;
    logic [BIN_WIDTH-1:0] sr;
    logic [BIN_WIDTH-1:0] sr_nxt;
    logic [CAT_W-1:0]     cat;
    logic [CNT_W-1:0]     cnt;
    logic                 ready;
    logic                 valid;
    logic [BIN_WIDTH-1:0] bin;
    logic                 ovf;

    // One step: shift {digits, binary} right, then correct every digit that reached >= 8
    always_comb begin
        cat     = {dig, sr} >> 1;
        dig_nxt = cat[CAT_W-1 -: DIG_W];
        sr_nxt  = cat[BIN_WIDTH-1:0];
        for (int i = 0; i < int'(BCD_WIDTH); i++) begin
            if (dig_nxt[i*4 +: 4] >= 4'd8) begin
                dig_nxt[i*4 +: 4] = dig_nxt[i*4 +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_2_BIN_CHECK_EN
    logic bad_in;
    logic bad;
    logic err;

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < int'(BCD_WIDTH); i++) begin
            if (bus.bcd_i[i*4 +: 4] > 4'd9) begin
                bad_in = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bad <= 1'b0;
            err <= 1'b0;
        end else if (state == IDLE && bus.start_i) begin
            bad <= bad_in;
        end else if (state == CONV && cnt == LAST) begin
            err <= bad;
        end
    end

    assign bus.err_o = err;
`else
    assign bus.err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            dig   <= '0;
            sr    <= '0;
            ready <= 1'b1;
            valid <= 1'b0;
            bin   <= '0;
            ovf   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        dig   <= bus.bcd_i;
                        sr    <= '0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    dig <= dig_nxt;
                    sr  <= sr_nxt;
                    cnt <= cnt + CNT_W'(1);
                    // Leftover digit content means the value did not fit in BIN_WIDTH bits
                    if (cnt == LAST) begin
                        bin   <= sr_nxt;
                        ovf   <= |dig_nxt;
                        valid <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = valid;
    assign bus.bin_o   = bin;
    assign bus.ovf_o   = ovf;
endmodule

// File: tb/tb_bcd_2_bin.sv
// Randomized self-checking bench for bcd_2_bin at BIN_WIDTH=10 and BIN_WIDTH=8.
module tb_bcd_2_bin;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    bcd_2_bin_if #(.BCD_WIDTH(3), .BIN_WIDTH(10)) bus10 ();
    bcd_2_bin_if #(.BCD_WIDTH(3), .BIN_WIDTH(8))  bus8 ();

    bcd_2_bin #(.BCD_WIDTH(3), .BIN_WIDTH(10)) u_dut10 (.clk_i(clk), .rst_i(rst), .bus(bus10));
    bcd_2_bin #(.BCD_WIDTH(3), .BIN_WIDTH(8))  u_dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned bcd_value(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [11:0] b);
        return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic exp_err(input logic [11:0] b);
`ifdef BCD_2_BIN_CHECK_EN
        return !bcd_ok(b);
`else
        return 1'b0;
`endif
    endfunction

    // Full request on both widths; checks latency, single pulse, result and flags
    task automatic convert(input logic [11:0] b);
        int          lat10, lat8, n10, n8;
        logic [9:0]  bin10;
        logic [7:0]  bin8;
        logic        ovf10, ovf8, err10, err8;
        int unsigned v;
        lat10 = -1; lat8 = -1; n10 = 0; n8 = 0;
        bin10 = '0; bin8 = '0; ovf10 = 1'b0; ovf8 = 1'b0; err10 = 1'b0; err8 = 1'b0;
        @(negedge clk);
        check("idle_ready10", 32'(bus10.ready_o), 32'(1));
        bus10.bcd_i = b; bus8.bcd_i = b;
        bus10.start_i = 1'b1; bus8.start_i = 1'b1;
        @(negedge clk);
        bus10.start_i = 1'b0; bus8.start_i = 1'b0;
        bus10.bcd_i = 12'($urandom); bus8.bcd_i = 12'($urandom);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 5) check("busy_ready10", 32'(bus10.ready_o), 32'(0));
            if (bus10.valid_o) begin
                n10++; lat10 = k; bin10 = bus10.bin_o; ovf10 = bus10.ovf_o; err10 = bus10.err_o;
                check("valid_ready10", 32'(bus10.ready_o), 32'(1));
            end
            if (bus8.valid_o) begin
                n8++; lat8 = k; bin8 = bus8.bin_o; ovf8 = bus8.ovf_o; err8 = bus8.err_o;
            end
        end
        v = bcd_value(b);
        check("latency10", 32'(lat10), 32'(10));
        check("latency8", 32'(lat8), 32'(8));
        check("pulses10", 32'(n10), 32'(1));
        check("pulses8", 32'(n8), 32'(1));
        check("err10", 32'(err10), 32'(exp_err(b)));
        check("err8", 32'(err8), 32'(exp_err(b)));
        if (bcd_ok(b)) begin
            check("bin10", 32'(bin10), v % 1024);
            check("ovf10", 32'(ovf10), 32'(v > 1023));
            check("bin8", 32'(bin8), v % 256);
            check("ovf8", 32'(ovf8), 32'(v > 255));
            check("hold_bin10", 32'(bus10.bin_o), v % 1024);
        end
    endtask

    initial begin
        int          lat, n;
        logic [9:0]  got;
        logic [11:0] b;
        rst = 1'b1;
        bus10.start_i = 1'b0; bus10.bcd_i = '0;
        bus8.start_i  = 1'b0; bus8.bcd_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus10.ready_o), 32'(1));
        check("rst_valid", 32'(bus10.valid_o), 32'(0));
        check("rst_bin", 32'(bus10.bin_o), 32'(0));
        check("rst_ovf", 32'(bus10.ovf_o), 32'(0));
        check("rst_err", 32'(bus10.err_o), 32'(0));
        // Reset overrides a request
        bus10.start_i = 1'b1; bus10.bcd_i = 12'h321;
        @(negedge clk);
        check("rst_over_start", 32'(bus10.ready_o), 32'(1));
        bus10.start_i = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus10.ready_o), 32'(1));

        convert(12'h999);
        convert(12'h000);
        convert(12'h255);
        convert(12'h1A3);
        convert(12'h193);
        convert(12'h0FF);

        // Back-to-back: second request issued in the valid cycle of the first
        @(negedge clk);
        bus10.bcd_i = 12'h000; bus10.start_i = 1'b1;
        @(negedge clk);
        bus10.start_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 14 && lat < 0; k++) begin
            @(negedge clk);
            if (bus10.valid_o) begin
                lat = k;
                check("b2b_first_bin", 32'(bus10.bin_o), 32'(0));
                bus10.bcd_i = 12'h255; bus10.start_i = 1'b1;
            end
        end
        check("b2b_first_lat", 32'(lat), 32'(10));
        @(negedge clk);
        bus10.start_i = 1'b0;
        lat = -1; got = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus10.valid_o && lat < 0) begin lat = k; got = bus10.bin_o; end
        end
        check("b2b_second_lat", 32'(lat), 32'(10));
        check("b2b_second_bin", 32'(got), 32'(255));

        // Request while busy is ignored
        @(negedge clk);
        bus10.bcd_i = 12'h123; bus10.start_i = 1'b1;
        @(negedge clk);
        bus10.start_i = 1'b0;
        n = 0; got = '0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 3) begin bus10.bcd_i = 12'h456; bus10.start_i = 1'b1; end
            if (k == 4) bus10.start_i = 1'b0;
            if (bus10.valid_o) begin n++; got = bus10.bin_o; end
        end
        check("busy_ignore_pulses", 32'(n), 32'(1));
        check("busy_ignore_bin", 32'(got), 32'(123));

        // Reset mid-conversion aborts it
        @(negedge clk);
        bus10.bcd_i = 12'h789; bus10.start_i = 1'b1;
        @(negedge clk);
        bus10.start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(bus10.ready_o), 32'(1));
        check("abort_valid", 32'(bus10.valid_o), 32'(0));
        check("abort_bin", 32'(bus10.bin_o), 32'(0));
        n = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus10.valid_o) n++;
        end
        check("abort_no_pulse", 32'(n), 32'(0));
        convert(12'h042);

        // Random requests, mostly valid BCD with some arbitrary nibbles
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                b = 12'($urandom);
            end else begin
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            convert(b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_2_bin.md
BCD_2_BIN -- requirements
Module: bcd_2_bin

Interface
REQ-001 Parameter BCD_WIDTH, default 3, is the number of 4-bit BCD digits at the input.
REQ-002 Parameter BIN_WIDTH, default 10, is the width of the binary result.
REQ-003 clk_i  input  1  is the single clock; all logic is rising-edge.
REQ-004 rst_i  input  1  is the synchronous, active-high reset.
REQ-005 start_i  input  1  is the conversion request, sampled only while ready_o=1.
REQ-006 bcd_i  input  BCD_WIDTH*4  is packed BCD with digit 0 in [3:0]; it is latched on accept.
REQ-007 ready_o  output  1  is high when idle and able to accept start_i.
REQ-008 valid_o  output  1  is a one-cycle pulse marking that bin_o, ovf_o and err_o are updated.
REQ-009 bin_o  output  BIN_WIDTH  is the converted binary value, held until the next valid_o.
REQ-010 ovf_o  output  1  is high when the decimal value exceeds 2^BIN_WIDTH-1; it is qualified by valid_o and held.
REQ-011 err_o  output  1  flags an invalid input digit; it is qualified by valid_o and held (see Configuration).

Function
REQ-012 The FSM has states IDLE and CONV only; the valid_o pulse is registered on the exit from CONV.
REQ-013 Accept: in IDLE with start_i=1 at edge E0, the block latches bcd_i into a digit register, clears the BIN_WIDTH shift register and step counter, and enters CONV.
REQ-014 Each CONV edge performs one reverse double-dabble step.
- Shift the concatenation {digit register, shift register} right by 1.
- Digit-0 LSB enters the shift-register MSB.
- Then, for each digit independently, if the digit is >=8, subtract 3 (4-bit).
REQ-015 After exactly BIN_WIDTH steps (edges E1..E_BIN_WIDTH), the block returns to IDLE.
- At edge E_BIN_WIDTH it registers the final shift register into bin_o and asserts valid_o for one cycle.
- Latency is BIN_WIDTH cycles from the accept edge to valid_o high.
REQ-016 ready_o is 0 from E0 through the valid_o cycle's preceding edge; ready_o=1 in the same cycle valid_o=1.
- Back-to-back accept is allowed in the valid_o cycle.
REQ-017 start_i while ready_o=0 is ignored; bcd_i changes while busy have no effect.
REQ-018 ovf_o=1 iff the digit register is nonzero after the last step.
- bin_o is then the value modulo 2^BIN_WIDTH.
REQ-019 bin_o, ovf_o and err_o change only at the edge that asserts valid_o.
REQ-020 Step counter width is clog2(BIN_WIDTH+1); no wrap occurs within a conversion.

Reset
REQ-021 rst_i=1 at any edge forces these values, overriding start_i:
- FSM=IDLE and counter=0.
- ready_o=1, valid_o=0.
- bin_o=0, ovf_o=0, err_o=0.
REQ-022 Reset during CONV aborts the conversion; no valid_o is produced for the aborted request.

Configuration
REQ-023 Macro BCD_2_BIN_CHECK_EN controls the invalid-digit check.
- Defined: at accept, the block records whether any latched digit is >9 and drives that flag onto err_o with valid_o.
- Defined: for invalid input, bin_o and ovf_o are still produced by REQ-014, and their values are unspecified.
- Not defined: err_o is constant 0 and no check logic is synthesized.

Verification
REQ-024 Default params, bcd_i=12'h999, start_i one cycle -> valid_o exactly 10 cycles after the accept edge, bin_o=999, ovf_o=0, err_o=0.
REQ-025 bcd_i=12'h000 -> bin_o=0; bcd_i=12'h255 -> bin_o=255; second start_i asserted in the valid_o cycle of the first -> accepted, second result 10 cycles later.
REQ-026 BIN_WIDTH=8, bcd_i=12'h999 -> bin_o=8'd231, ovf_o=1; bcd_i=12'h255 -> bin_o=255, ovf_o=0.
REQ-027 start_i with bcd_i=12'h123, then start_i with 12'h456 on cycle 3 -> single valid_o with bin_o=123; no second result.
REQ-028 rst_i pulsed on cycle 5 of a conversion -> no valid_o, ready_o=1 the next cycle, bin_o=0; a new 12'h042 request -> bin_o=42.
REQ-029 With BCD_2_BIN_CHECK_EN, bcd_i=12'h1A3 -> err_o=1 with valid_o; 12'h193 -> err_o=0. Without the macro -> err_o=0 always.
